// File: rtl/median_window_feeder.sv
// Line-buffered 3x3 window feeder for the 9-pixel median core: stores three
// raster lines and serialises every interior neighbourhood onto DSI/DI.
module median_window_feeder #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     PIX_VALID,
  output logic                     PIX_READY,
  input  logic [WIDTH-1:0]         PIX_DATA,
  input  logic                     PIX_SOF,
  output logic                     MED_DSI,
  output logic [WIDTH-1:0]         MED_DI,
  input  logic                     MED_DSO,
  output logic [$clog2(IMG_W)-1:0] WIN_X,
  output logic [$clog2(IMG_H)-1:0] WIN_Y,
  output logic                     FRAME_DONE
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {ACCEPT = 2'd0, SEND = 2'd1, WAIT = 2'd2} state_t;

  function automatic logic [1:0] slot_inc(input logic [1:0] s);
    logic [1:0] r;
    case (s)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  state_t           state_r;
  logic [XW-1:0]    col_r;
  logic [YW-1:0]    row_r;
  logic [1:0]       slot_r;
  logic [XW-1:0]    rd_col_r;
  logic [1:0]       rd_slot_r;
  logic [3:0]       k_r;
  logic             last_r;
  logic [WIDTH-1:0] store_r [3][IMG_W];

  logic             acc_s;
  logic             trig_s;
  logic [XW-1:0]    eff_col_s;
  logic [YW-1:0]    eff_row_s;
  logic [1:0]       eff_slot_s;
  logic [1:0]       top_slot_s;
  logic [XW-1:0]    nxt_col_s;
  logic [1:0]       nxt_slot_s;

  // Effective position (SOF forces 0,0), window trigger and next read address.
  always_comb begin
    acc_s      = PIX_VALID & PIX_READY;
    eff_col_s  = PIX_SOF ? {XW{1'b0}} : col_r;
    eff_row_s  = PIX_SOF ? {YW{1'b0}} : row_r;
    eff_slot_s = PIX_SOF ? 2'd0 : slot_r;
    trig_s     = (eff_row_s >= YW'(2)) && (eff_col_s >= XW'(2));
    // Oldest of the three lines lives in the slot after the current one.
    top_slot_s = slot_inc(eff_slot_s);
    if (rd_col_r == WIN_X + XW'(1)) begin
      nxt_col_s  = WIN_X - XW'(1);
      nxt_slot_s = slot_inc(rd_slot_r);
    end else begin
      nxt_col_s  = rd_col_r + XW'(1);
      nxt_slot_s = rd_slot_r;
    end
  end

  // Line store write; contents need no reset.
  always_ff @(posedge CLK) begin
    if (acc_s) begin
      store_r[eff_slot_s][eff_col_s] <= PIX_DATA;
    end
  end

  // Control FSM with registered handshake, window and frame outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r    <= ACCEPT;
      col_r      <= {XW{1'b0}};
      row_r      <= {YW{1'b0}};
      slot_r     <= 2'd0;
      rd_col_r   <= {XW{1'b0}};
      rd_slot_r  <= 2'd0;
      k_r        <= 4'd0;
      last_r     <= 1'b0;
      PIX_READY  <= 1'b0;
      MED_DSI    <= 1'b0;
      MED_DI     <= {WIDTH{1'b0}};
      WIN_X      <= {XW{1'b0}};
      WIN_Y      <= {YW{1'b0}};
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state_r)
        ACCEPT: begin
          if (acc_s) begin
            if (eff_col_s == COL_LAST) begin
              col_r <= {XW{1'b0}};
              if (eff_row_s == ROW_LAST) begin
                row_r  <= {YW{1'b0}};
                slot_r <= 2'd0;
              end else begin
                row_r  <= eff_row_s + YW'(1);
                slot_r <= slot_inc(eff_slot_s);
              end
            end else begin
              col_r  <= eff_col_s + XW'(1);
              row_r  <= eff_row_s;
              slot_r <= eff_slot_s;
            end
            if (trig_s) begin
              // Element 0 is never the pixel being written, so read it now.
              WIN_X     <= eff_col_s - XW'(1);
              WIN_Y     <= eff_row_s - YW'(1);
              last_r    <= (eff_col_s == COL_LAST) && (eff_row_s == ROW_LAST);
              MED_DI    <= store_r[top_slot_s][eff_col_s - XW'(2)];
              MED_DSI   <= 1'b1;
              rd_slot_r <= top_slot_s;
              rd_col_r  <= eff_col_s - XW'(2);
              k_r       <= 4'd0;
              PIX_READY <= 1'b0;
              state_r   <= SEND;
            end else begin
              PIX_READY <= 1'b1;
            end
          end else begin
            PIX_READY <= 1'b1;
          end
        end
        SEND: begin
          if (k_r == 4'd8) begin
            MED_DSI <= 1'b0;
            MED_DI  <= {WIDTH{1'b0}};
            state_r <= WAIT;
          end else begin
            k_r       <= k_r + 4'd1;
            rd_col_r  <= nxt_col_s;
            rd_slot_r <= nxt_slot_s;
            MED_DI    <= store_r[nxt_slot_s][nxt_col_s];
          end
        end
        WAIT: begin
          if (MED_DSO) begin
            PIX_READY  <= 1'b1;
            FRAME_DONE <= last_r;
            state_r    <= ACCEPT;
          end else begin
            PIX_READY <= 1'b0;
          end
        end
        default: begin
          PIX_READY <= 1'b0;
          MED_DSI   <= 1'b0;
          state_r   <= ACCEPT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder on a 4x4 image: a frame-array reference model
// predicts every 3x3 window; directed steps cover reset, stalls and resync.
module tb_median_window_feeder;
  localparam int W = 4;
  localparam int H = 4;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       PIX_VALID = 1'b0;
  logic       PIX_READY;
  logic [7:0] PIX_DATA = 8'd0;
  logic       PIX_SOF = 1'b0;
  logic       MED_DSI;
  logic [7:0] MED_DI;
  logic       MED_DSO = 1'b0;
  logic [1:0] WIN_X;
  logic [1:0] WIN_Y;
  logic       FRAME_DONE;

  median_window_feeder #(.WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
    .CLK(CLK), .nRST(nRST), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .PIX_DATA(PIX_DATA), .PIX_SOF(PIX_SOF), .MED_DSI(MED_DSI), .MED_DI(MED_DI),
    .MED_DSO(MED_DSO), .WIN_X(WIN_X), .WIN_Y(WIN_Y), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct { int x; int y; logic [8:0][7:0] v; } win_t;
  win_t exp_q[$], got_q[$], clean_q[$];
  win_t cur, e;
  logic [7:0] frame_m [H][W];
  int  pos = 0, checks = 0, errors = 0, fd_cnt = 0, dso_delay = 5, run = 0;
  bit  spur = 1'b0;
  time dso_fire_t = 0;
  int  cx[4] = '{1, 2, 1, 2};
  int  cy[4] = '{1, 1, 2, 2};

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: place pixel in the frame by raster index, emit window if interior.
  function automatic void model_accept(input logic [7:0] d, input logic sof);
    int r, c;
    win_t w;
    if (sof) pos = 0;
    r = pos / W;
    c = pos % W;
    frame_m[r][c] = d;
    if (r >= 2 && c >= 2) begin
      w.x = c - 1;
      w.y = r - 1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w.v[i*3+j] = frame_m[r-2+i][c-2+j];
      exp_q.push_back(w);
    end
    pos = (pos + 1) % (W * H);
  endfunction

  task automatic push(input logic [7:0] d, input logic sof, input int gap);
    int t = 0;
    PIX_DATA = d; PIX_SOF = sof; PIX_VALID = 1'b1;
    while (PIX_READY !== 1'b1 && t < 400) begin @(negedge CLK); t++; end
    chk("accept_timeout", 72'(t < 400), 72'(1));
    @(posedge CLK);
    model_accept(d, sof);
    @(negedge CLK);
    PIX_VALID = 1'b0; PIX_SOF = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic run_frame(input bit sof0, input int gap, input bit rnd);
    for (int i = 0; i < W * H; i++)
      push(rnd ? 8'($urandom) : 8'(i), sof0 && (i == 0),
           (gap == 2) ? int'($urandom_range(2, 0)) : gap);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || PIX_READY !== 1'b1) && t < 600) begin @(negedge CLK); t++; end
    chk("drain_timeout", 72'(t < 600), 72'(1));
    repeat (3) @(negedge CLK);
  endtask

  task automatic cmp_clean(input string tag);
    chk({tag, "_count"}, 72'(got_q.size()), 72'(4));
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_di"}, 72'(got_q[k].v), 72'(clean_q[k].v));
      chk({tag, "_x"}, 72'(got_q[k].x), 72'(cx[k]));
      chk({tag, "_y"}, 72'(got_q[k].y), 72'(cy[k]));
    end
  endtask

  // Window monitor: collects DSI bursts and checks them against the model.
  always @(negedge CLK) begin
    if (!nRST) begin
      run = 0;
    end else begin
      if (MED_DSI === 1'b1) begin
        if (run == 0) begin cur.x = int'(WIN_X); cur.y = int'(WIN_Y); end
        if (run < 9) cur.v[run] = MED_DI;
        run++;
        if (run == 9) begin
          got_q.push_back(cur);
          if (exp_q.size() == 0) chk("unexpected_window", 72'(exp_q.size()), 72'(1));
          else begin
            e = exp_q.pop_front();
            chk("win_x", 72'(cur.x), 72'(e.x));
            chk("win_y", 72'(cur.y), 72'(e.y));
            for (int k = 0; k < 9; k++) chk("win_di", 72'(cur.v[k]), 72'(e.v[k]));
          end
        end
      end else if (run != 0) begin
        chk("dsi_run_length", 72'(run), 72'(9));
        run = 0;
      end
      if (FRAME_DONE === 1'b1) begin
        fd_cnt++;
        chk("fd_with_ready", 72'(PIX_READY), 72'(1));
      end
    end
  end

  // Median-core stand-in: returns DSO dso_delay cycles after each burst.
  initial begin
    int  cnt = 0;
    bit  prev_dsi = 1'b0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        cnt = 0; prev_dsi = 1'b0; MED_DSO = 1'b0;
      end else begin
        MED_DSO = spur && (MED_DSI || PIX_READY);
        if (prev_dsi && !MED_DSI) cnt = dso_delay;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin MED_DSO = 1'b1; dso_fire_t = $time; end
        end
        prev_dsi = MED_DSI;
      end
    end
  end

  initial begin
    int fd0, t;
    bit bad;
    logic [8:0][7:0] first_v, last_v;
    first_v = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    last_v  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};

    repeat (3) @(negedge CLK);
    chk("rst_ready", 72'(PIX_READY), 72'(0));
    chk("rst_dsi", 72'(MED_DSI), 72'(0));
    chk("rst_di", 72'(MED_DI), 72'(0));
    chk("rst_winx", 72'(WIN_X), 72'(0));
    chk("rst_winy", 72'(WIN_Y), 72'(0));
    chk("rst_fd", 72'(FRAME_DONE), 72'(0));
    nRST = 1'b1;
    @(negedge CLK);
    chk("ready_after_release", 72'(PIX_READY), 72'(1));

    // Clean 4x4 frame, value = index.
    got_q.delete(); fd0 = fd_cnt;
    run_frame(1'b1, 0, 1'b0);
    drain();
    chk("clean_count", 72'(got_q.size()), 72'(4));
    for (int k = 0; k < 4; k++) begin
      chk("clean_x", 72'(got_q[k].x), 72'(cx[k]));
      chk("clean_y", 72'(got_q[k].y), 72'(cy[k]));
    end
    chk("first_window", 72'(got_q[0].v), 72'(first_v));
    chk("last_window", 72'(got_q[3].v), 72'(last_v));
    chk("clean_frame_done", 72'(fd_cnt - fd0), 72'(1));
    clean_q = got_q;

    // Backpressure: DSO withheld for ~100 cycles with a pixel pending.
    got_q.delete(); fd0 = fd_cnt; dso_delay = 100;
    for (int i = 0; i <= 10; i++) push(8'(i), i == 0, 0);
    PIX_DATA = 8'd11; PIX_SOF = 1'b0; PIX_VALID = 1'b1;
    bad = 1'b0;
    repeat (95) begin @(negedge CLK); if (PIX_READY !== 1'b0) bad = 1'b1; end
    chk("bp_ready_low", 72'(bad), 72'(0));
    t = 0;
    while (PIX_READY !== 1'b1 && t < 100) begin @(negedge CLK); t++; end
    chk("bp_resume_latency", 72'($time - dso_fire_t), 72'(10));
    dso_delay = 5;
    for (int i = 11; i < 16; i++) push(8'(i), 1'b0, 0);
    drain();
    cmp_clean("bp");
    chk("bp_frame_done", 72'(fd_cnt - fd0), 72'(1));

    // Spurious DSO during SEND and ACCEPT.
    got_q.delete(); fd0 = fd_cnt; spur = 1'b1;
    run_frame(1'b1, 0, 1'b0);
    drain();
    spur = 1'b0;
    cmp_clean("spur");
    chk("spur_frame_done", 72'(fd_cnt - fd0), 72'(1));

    // Truncated frame followed by SOF resync.
    got_q.delete(); fd0 = fd_cnt;
    for (int i = 0; i < 6; i++) push(8'($urandom), 1'b0, 0);
    run_frame(1'b1, 0, 1'b0);
    drain();
    cmp_clean("resync");
    chk("resync_frame_done", 72'(fd_cnt - fd0), 72'(1));

    // Gapped input, valid toggling every cycle.
    got_q.delete(); fd0 = fd_cnt;
    run_frame(1'b1, 1, 1'b0);
    drain();
    cmp_clean("gapped");
    chk("gapped_frame_done", 72'(fd_cnt - fd0), 72'(1));

    // Random data, random gaps, random DSO delay.
    for (int n = 0; n < 2; n++) begin
      got_q.delete(); fd0 = fd_cnt; dso_delay = int'($urandom_range(8, 1));
      run_frame(1'b1, 2, 1'b1);
      drain();
      chk("rand_count", 72'(got_q.size()), 72'(4));
      chk("rand_frame_done", 72'(fd_cnt - fd0), 72'(1));
    end
    dso_delay = 5;

    // Reset in the middle of a SEND burst.
    for (int i = 0; i <= 10; i++) push(8'(i), i == 0, 0);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_dsi", 72'(MED_DSI), 72'(0));
    chk("midrst_ready", 72'(PIX_READY), 72'(0));
    chk("midrst_fd", 72'(FRAME_DONE), 72'(0));
    exp_q.delete(); pos = 0;
    repeat (2) @(negedge CLK);
    got_q.delete();
    nRST = 1'b1;
    @(negedge CLK);
    chk("midrst_ready_release", 72'(PIX_READY), 72'(1));
    fd0 = fd_cnt;
    run_frame(1'b0, 0, 1'b0);
    drain();
    cmp_clean("postrst");
    chk("postrst_frame_done", 72'(fd_cnt - fd0), 72'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/median_window_feeder.md
Name: median_window_feeder

Overview:
Upstream stage of the 9-pixel median core. Accepts a raster pixel stream (valid/ready), holds the last three image lines in a circular line store, and for every interior pixel position serialises the 3x3 neighbourhood onto the core's DSI/DI input. It then stalls until the core's DSO marks the median result as available.

Parameters:
WIDTH, 8, pixel bit width (matches median core DI/DO)
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  reset, asynchronous, active-low
PIX_VALID  input  1  input pixel valid
PIX_READY  output  1  feeder can accept a pixel this cycle
PIX_DATA  input  WIDTH  input pixel value
PIX_SOF  input  1  qualifies the accepted pixel as frame position (0,0)
MED_DSI  output  1  window load strobe to median core, high for exactly 9 cycles per window
MED_DI  output  WIDTH  window pixel to median core, valid while MED_DSI=1
MED_DSO  input  1  median core result strobe
WIN_X  output  clog2(IMG_W)  centre column of the current/last window
WIN_Y  output  clog2(IMG_H)  centre row of the current/last window
FRAME_DONE  output  1  one-cycle pulse after the last window of a frame completes

Behaviour:
- Reset (asynchronous, nRST=0): state=ACCEPT; col=row=0; PIX_READY=0 while nRST=0, then 1 from the first clock after release; MED_DSI=0; MED_DI=0; WIN_X=WIN_Y=0; FRAME_DONE=0. Line store contents are don't-care.
- Reset mid-window: the window is dropped and no DSI pulse resumes. The downstream core is reset by the same nRST.
- Accept: a pixel is accepted on a rising edge with PIX_VALID=1 and PIX_READY=1. PIX_READY=1 only in state ACCEPT (registered, no combinational path from PIX_VALID).
- Storage: the accepted pixel is written to line store slot [row mod 3][col].
- Counters: col increments, wrapping at IMG_W-1 to 0 with row+1; row wraps at IMG_H-1 to 0. An accepted pixel with PIX_SOF=1 is treated as (0,0), overriding the counters; subsequent counting resumes from (0,1).
- Window trigger: the accepted pixel (row r, col c) with r>=2 and c>=2 completes the window centred at (r-1, c-1). WIN_X/WIN_Y are loaded with c-1/r-1, and the state goes to SEND on the next cycle. Otherwise the state stays ACCEPT.
- Border output: none. Border pixels produce no window; one frame yields (IMG_W-2)*(IMG_H-2) windows.
- SEND (9 cycles, k=0..8): MED_DSI=1 and MED_DI=window element k, in row-major order from top-left (r-2,c-2) to bottom-right (r,c). Element 8 is the just-accepted pixel, read from the store or a bypass register. After k=8 the state goes to WAIT, with MED_DSI=0 on the following cycle.
- WAIT: PIX_READY=0 and MED_DSI=0 until MED_DSO=1 is sampled, then ACCEPT on the next cycle.
- MED_DSO outside WAIT is ignored.
- MED_DSO may arrive an arbitrary number of cycles after SEND; no timeout.
- FRAME_DONE: if the completed window was the last of the frame (centre IMG_W-2, IMG_H-2), FRAME_DONE=1 for exactly one cycle, the same cycle the state re-enters ACCEPT.
- PIX_SOF with a non-zero counter position (truncated frame): counters restart, the line store is reused, and no FRAME_DONE is issued for the truncated frame.
- Throughput: at most one pixel per cycle in ACCEPT. Each window costs 9 SEND cycles plus the WAIT duration. Minimum latency from accepting the window-completing pixel to the first MED_DSI=1 is 1 cycle.

Test Plan:
- Reset: nRST=0 mid-SEND -> MED_DSI=0, PIX_READY=0, FRAME_DONE=0 immediately; after release, PIX_READY=1 and col=row=0.
- IMG_W=4, IMG_H=4, pixels 0..15 (value=index), PIX_SOF on pixel 0, DSO returned 5 cycles after SEND:
  - exactly 4 windows are sent, centres (1,1),(2,1),(1,2),(2,2);
  - first window DI sequence = 0,1,2,4,5,6,8,9,10;
  - last window DI sequence = 5,6,7,9,10,11,13,14,15;
  - FRAME_DONE pulses once.
- Backpressure: hold MED_DSO=0 for 100 cycles in WAIT -> PIX_READY stays 0, no pixel lost. Then assert DSO -> next pixel accepted 1 cycle later.
- Spurious DSO: MED_DSO=1 during SEND and ACCEPT -> no state change; the window still spans exactly 9 DSI cycles.
- SOF resync: send 6 pixels, then PIX_SOF with a new frame of 16 pixels -> the window sequence is identical to the clean-frame case and FRAME_DONE pulses once.
- Gapped input: PIX_VALID toggling 1/0 every cycle -> DI sequences are unchanged versus the continuous stream.
